// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: line-granular main-memory backend for the direct-mapped cache.
// Accepts one 128-bit line read or write-back at a time. It answers after
// LATENCY cycles with a one-cycle ready strobe.
//
// Handshake: a request is taken on any rising edge where the FSM is IDLE and
// i_mem_req_valid = 1. There is no request-side ready. The requester sees
// o_busy = 1 while a request is outstanding. The completion is
// o_mem_data_ready, which is high for exactly one cycle. o_mem_err qualifies
// that cycle only. Request inputs are ignored in BUSY and RESP.
module main_mem_ctrl #(
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [31:0]  i_mem_req_addr,
  input  logic [127:0] i_mem_req_data,
  input  logic         i_mem_req_rw,
  input  logic         i_mem_req_valid,
  output logic [127:0] o_mem_data_data,
  output logic         o_mem_data_ready,
  output logic         o_mem_err,
  output logic         o_busy,
  output logic [1:0]   o_dbg_state
);

  localparam int IW = $clog2(DEPTH_LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:4]     r_addr;   // byte offset bits are dropped: accesses are whole lines
  logic [127:0]    r_data;
  logic            r_rw;
  logic [127:0]    r_rdata;
  logic            r_ready;
  logic            r_err;
  logic            r_busy;

  // Line store; not touched by reset, powers up zero on the FPGA target.
  logic [127:0]    r_mem [DEPTH_LINES];

  logic [IW-1:0]   w_idx;
  logic            w_oor;
  logic            w_commit;
  logic            w_mem_we;
  logic            w_unused;

  assign w_idx    = r_addr[IW+3:4];
  assign w_oor    = |r_addr[31:IW+4];
  assign w_commit = (r_state == S_BUSY) && (r_cnt == '0);
  // Reset on the commit edge must also drop the write.
  assign w_mem_we = w_commit && r_rw && !w_oor && !i_reset;
  assign w_unused = ^i_mem_req_addr[3:0];

  // Control FSM with registered outputs; the access happens on the BUSY->RESP edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rw    <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          if (i_mem_req_valid) begin
            r_addr  <= i_mem_req_addr[31:4];
            r_data  <= i_mem_req_data;
            r_rw    <= i_mem_req_rw;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            if (w_oor) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end else if (!r_rw) begin
              r_rdata <= r_mem[w_idx];
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port, committed only on an in-range write completion.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_data;
    end
  end

  assign o_mem_data_data  = r_rdata;
  assign o_mem_data_ready = r_ready;
  assign o_mem_err        = r_err;
  assign o_busy           = r_busy;
  assign o_dbg_state      = r_state;

endmodule
